// File: rtl/dac_pkg.sv
// Shared definitions for the galvo DAC driver.
// Holds the top-level FSM state type, the MCP4922-style command nibbles
// for each channel, the SPI word width and a word-assembly helper.
package dac_pkg;

  localparam int unsigned WORD_W = 16;

  // {A/B, BUF=0, GA_n=1, SHDN_n=1}
  localparam logic [3:0] CFG_X = 4'b0011;
  localparam logic [3:0] CFG_Y = 4'b1011;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP_X,
    ST_SHIFT_X,
    ST_GAP_X,
    ST_SETUP_Y,
    ST_SHIFT_Y,
    ST_GAP_Y,
    ST_LATCH,
    ST_DONE
  } state_t;

  function automatic logic [WORD_W-1:0] dac_word(input logic [3:0] cfg,
                                                 input logic [11:0] code);
    return {cfg, code};
  endfunction

endpackage

// File: rtl/dac_drive_if.sv
// DAC pin bundle for the galvo driver.
//   dac_mosi  : SPI data, MSB first
//   dac_CSN   : SPI chip select, active low
//   dac_sclk  : SPI clock, idle low
//   dac_latch : DAC LDAC, active low
// master = driver side, slave = DAC side.
interface dac_drive_if;
  logic dac_mosi;
  logic dac_CSN;
  logic dac_sclk;
  logic dac_latch;

  modport master (output dac_mosi, output dac_CSN, output dac_sclk, output dac_latch);
  modport slave  (input  dac_mosi, input  dac_CSN, input  dac_sclk, input  dac_latch);
endinterface

// File: rtl/dac_drive_spi_shift16.sv
// One 16-bit SPI frame engine.
// A load pulse captures the word and starts a frame: one setup cycle with
// CSN low, sclk low and the MSB on mosi, then 16 bits of CLK_DIV-high /
// CLK_DIV-low sclk, mosi advancing on each falling edge.
//   clk, reset : clock, async active-high reset
//   load, word : start a frame with this word (ignored while active)
//   csn, sclk, mosi : registered SPI outputs
//   frame_last : high in the final cycle of the frame (before CSN rises)
module spi_shift16
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              csn,
  output logic              sclk,
  output logic              mosi,
  output logic              frame_last
);

  logic              active;
  logic              setup;
  logic [15:0]       div_cnt;
  logic [3:0]        bit_cnt;
  logic [WORD_W-2:0] shreg;
  logic              div_last;

  assign div_last   = (div_cnt == 16'(CLK_DIV - 1));
  assign frame_last = active && !setup && !sclk && div_last && (bit_cnt == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      setup   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      csn     <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (!active) begin
      if (load) begin
        active  <= 1'b1;
        setup   <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        shreg   <= word[WORD_W-2:0];
        csn     <= 1'b0;
        sclk    <= 1'b0;
        mosi    <= word[WORD_W-1];
      end
    end else if (setup) begin
      setup <= 1'b0;
      sclk  <= 1'b1;
    end else if (!div_last) begin
      div_cnt <= div_cnt + 16'd1;
    end else begin
      div_cnt <= '0;
      if (sclk) begin
        sclk  <= 1'b0;
        mosi  <= shreg[WORD_W-2];
        shreg <= {shreg[WORD_W-3:0], 1'b0};
      end else if (bit_cnt == 4'd15) begin
        active <= 1'b0;
        csn    <= 1'b1;
        mosi   <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        sclk    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_drive.sv
// Dual-channel 12-bit SPI DAC driver for the projector galvos.
// On start, captures (x, y, rgb), sends X to channel A and Y to channel B
// as two SPI frames separated by a CSN-high gap, then pulses LDAC so both
// axes move together, releasing the colour on the same cycle, and pulses done.
//   clk, reset        : clock, async active-high reset
//   x_in, y_in        : 12-bit position codes, sampled on start
//   start             : request one point (ignored unless idle)
//   laser_rgb         : colour enables {R,G,B}, sampled on start
//   bus               : DAC pins (mosi, CSN, sclk, LDAC)
//   done              : one-cycle pulse after the latch
//   laser_rgb_latched : colour aligned to the DAC update
module dac_drive
  import dac_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned LATCH_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        start,
  input  logic [2:0]  laser_rgb,
  dac_drive_if.master bus,
  output logic        done,
  output logic [2:0]  laser_rgb_latched
);

  state_t            state;
  logic [11:0]       y_q;
  logic [2:0]        rgb_q;
  logic [15:0]       cnt;
  logic              latch_n;
  logic              load_x;
  logic              load_y;
  logic [WORD_W-1:0] word;
  logic              csn;
  logic              sclk;
  logic              mosi;
  logic              frame_last;

  // The X frame starts on the start edge itself, so its word comes straight
  // from x_in; Y is loaded from the captured copy at the end of the X gap.
  assign load_x = (state == ST_IDLE) && start;
  assign load_y = (state == ST_GAP_X) && (cnt == 16'(CS_GAP - 1));
  assign word   = load_y ? dac_word(CFG_Y, y_q) : dac_word(CFG_X, x_in);

  spi_shift16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (load_x || load_y),
    .word       (word),
    .csn        (csn),
    .sclk       (sclk),
    .mosi       (mosi),
    .frame_last (frame_last)
  );

  assign bus.dac_mosi  = mosi;
  assign bus.dac_CSN   = csn;
  assign bus.dac_sclk  = sclk;
  assign bus.dac_latch = latch_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      y_q               <= '0;
      rgb_q             <= '0;
      cnt               <= '0;
      latch_n           <= 1'b1;
      done              <= 1'b0;
      laser_rgb_latched <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            y_q   <= y_in;
            rgb_q <= laser_rgb;
            state <= ST_SETUP_X;
          end
        end
        ST_SETUP_X: state <= ST_SHIFT_X;
        ST_SHIFT_X: begin
          if (frame_last) begin
            cnt   <= '0;
            state <= ST_GAP_X;
          end
        end
        ST_GAP_X: begin
          if (load_y) state <= ST_SETUP_Y;
          else        cnt   <= cnt + 16'd1;
        end
        ST_SETUP_Y: state <= ST_SHIFT_Y;
        ST_SHIFT_Y: begin
          if (frame_last) begin
            cnt   <= '0;
            state <= ST_GAP_Y;
          end
        end
        ST_GAP_Y: begin
          if (cnt == 16'(CS_GAP - 1)) begin
            cnt               <= '0;
            latch_n           <= 1'b0;
            laser_rgb_latched <= rgb_q;
            state             <= ST_LATCH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_LATCH: begin
          if (cnt == 16'(LATCH_W - 1)) begin
            latch_n <= 1'b1;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_drive.sv
// Directed bench for dac_drive: decodes the SPI frames seen on the pins,
// measures latch/done timing and framing, and compares against hand-computed
// values for each point.
module tb_dac_drive;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] x_in = '0;
  logic [11:0] y_in = '0;
  logic [2:0]  laser_rgb = '0;
  logic        done;
  logic [2:0]  laser_rgb_latched;

  dac_drive_if bus();

  dac_drive #(.CLK_DIV(2), .CS_GAP(2), .LATCH_W(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .x_in              (x_in),
    .y_in              (y_in),
    .start             (start),
    .laser_rgb         (laser_rgb),
    .bus               (bus),
    .done              (done),
    .laser_rgb_latched (laser_rgb_latched)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- pin monitor ----------------
  int unsigned cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [15:0] sh = '0;
  int          edges = 0;
  logic [15:0] frames[$];
  int          edge_q[$];
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  int          latch_cycles = 0;
  int          sclk_bad = 0;
  int          latch_bad = 0;
  int          min_gap = 1000;
  int          csn_run = 0;
  logic [2:0]  rgb_at_latch = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_csn = 1'b1;
  logic        prev_latch = 1'b1;

  initial forever begin
    @(negedge clk);
    if (!bus.dac_CSN && bus.dac_sclk && !prev_sclk) begin
      sh = {sh[14:0], bus.dac_mosi};
      edges++;
    end
    if (bus.dac_CSN && !prev_csn) begin
      frames.push_back(sh);
      edge_q.push_back(edges);
      edges = 0;
    end
    if (!bus.dac_CSN && prev_csn && csn_run < min_gap) min_gap = csn_run;
    csn_run = bus.dac_CSN ? csn_run + 1 : 0;
    if (bus.dac_CSN && prev_csn && bus.dac_sclk != prev_sclk) sclk_bad++;
    if (!bus.dac_latch && !bus.dac_CSN) latch_bad++;
    if (!bus.dac_latch) latch_cycles++;
    if (!bus.dac_latch && prev_latch) rgb_at_latch = laser_rgb_latched;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_sclk  = bus.dac_sclk;
    prev_csn   = bus.dac_CSN;
    prev_latch = bus.dac_latch;
  end

  task automatic clear_mon();
    frames.delete();
    edge_q.delete();
    edges        = 0;
    done_cnt     = 0;
    done_cyc     = 0;
    latch_cycles = 0;
    sclk_bad     = 0;
    latch_bad    = 0;
    min_gap      = 1000;
    rgb_at_latch = '0;
  endtask

  task automatic check_idle_pins(input string tag, input logic [2:0] exp_rgb);
    check($sformatf("%s_csn", tag),   {31'b0, bus.dac_CSN},   32'd1);
    check($sformatf("%s_sclk", tag),  {31'b0, bus.dac_sclk},  32'd0);
    check($sformatf("%s_latch", tag), {31'b0, bus.dac_latch}, 32'd1);
    check($sformatf("%s_done", tag),  {31'b0, done},          32'd0);
    check($sformatf("%s_rgb", tag),   {29'b0, laser_rgb_latched}, {29'b0, exp_rgb});
  endtask

  // Send one point; optionally disturb inputs right after start (chg) or
  // fire a second start 20 cycles in (busy). Expected words/colour are given.
  task automatic run_point(input string tag,
                           input logic [11:0] x, input logic [11:0] y, input logic [2:0] rgb,
                           input bit chg, input bit busy,
                           input logic [15:0] exp_w0, input logic [15:0] exp_w1,
                           input logic [2:0] exp_rgb);
    int unsigned s;
    logic [15:0] f0, f1;
    int e0, e1;
    @(posedge clk);
    #1 clear_mon();
    @(negedge clk);
    x_in = x; y_in = y; laser_rgb = rgb; start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    if (chg) begin
      x_in = ~x; y_in = ~y; laser_rgb = ~rgb;
    end
    if (busy) begin
      repeat (19) @(posedge clk);
      #1 start = 1'b1; x_in = 12'hFFF; y_in = 12'hFFF; laser_rgb = 3'b111;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != 0) break;
    end
    check($sformatf("%s_done_seen", tag), {31'b0, done_cnt != 0}, 32'd1);
    repeat (10) @(negedge clk);
    #1;
    f0 = (frames.size() > 0) ? frames[0] : 16'hxxxx;
    f1 = (frames.size() > 1) ? frames[1] : 16'hxxxx;
    e0 = (edge_q.size() > 0) ? edge_q[0] : -1;
    e1 = (edge_q.size() > 1) ? edge_q[1] : -1;
    check($sformatf("%s_nframes", tag), frames.size(), 32'd2);
    check($sformatf("%s_word_x", tag), {16'b0, f0}, {16'b0, exp_w0});
    check($sformatf("%s_word_y", tag), {16'b0, f1}, {16'b0, exp_w1});
    check($sformatf("%s_edges_x", tag), e0, 32'd16);
    check($sformatf("%s_edges_y", tag), e1, 32'd16);
    check($sformatf("%s_done_cnt", tag), done_cnt, 32'd1);
    check($sformatf("%s_done_lat", tag), done_cyc - s, 32'd137);
    check($sformatf("%s_latch_w", tag), latch_cycles, 32'd2);
    check($sformatf("%s_rgb_entry", tag), {29'b0, rgb_at_latch}, {29'b0, exp_rgb});
    check($sformatf("%s_rgb_hold", tag), {29'b0, laser_rgb_latched}, {29'b0, exp_rgb});
    check($sformatf("%s_sclk_csn_hi", tag), sclk_bad, 32'd0);
    check($sformatf("%s_latch_csn_lo", tag), latch_bad, 32'd0);
    check($sformatf("%s_gap_ge2", tag), {31'b0, min_gap >= 2}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_pins("rst", 3'b000);
    check("rst_mosi", {31'b0, bus.dac_mosi}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_point("p1", 12'hF0F, 12'h8F0, 3'b101, 1'b0, 1'b0, 16'h3F0F, 16'hB8F0, 3'b101);
    check("p2_rgb_before", {29'b0, laser_rgb_latched}, 32'd5);
    run_point("p2", 12'h000, 12'h000, 3'b101, 1'b0, 1'b0, 16'h3000, 16'hB000, 3'b101);
    run_point("busy", 12'h123, 12'h456, 3'b010, 1'b0, 1'b1, 16'h3123, 16'hB456, 3'b010);
    run_point("inchg", 12'hA5A, 12'h5A5, 3'b011, 1'b1, 1'b0, 16'h3A5A, 16'hB5A5, 3'b011);

    // Reset in the middle of the X frame.
    @(negedge clk);
    x_in = 12'h777; y_in = 12'h333; laser_rgb = 3'b110; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_idle_pins("midrst", 3'b000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 clear_mon();
    repeat (200) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt, 32'd0);
    check("midrst_no_latch", latch_cycles, 32'd0);
    check("midrst_no_frames", frames.size(), 32'd0);
    check("midrst_rgb_after", {29'b0, laser_rgb_latched}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_drive.md
Name: dac_drive

Overview:
- Drives a dual-channel 12-bit SPI DAC (MCP4922-style 16-bit command words, active-low LDAC) that positions the laser-projector galvos.
- On `start` it captures an (x, y, colour) point and shifts X to channel A, then Y to channel B.
- It then pulses LDAC so both axes update simultaneously, and releases the colour in step with the latch.
- It sits between the point/vector generator and the DAC pins.

Parameters:
- CLK_DIV, 2, sclk half-period in clk cycles (sclk = clk/(2*CLK_DIV)); must be ≥ 1.
- CS_GAP, 2, clk cycles CSN is held high between frames and after the last frame; must be ≥ 1.
- LATCH_W, 2, clk cycles dac_latch is held low; must be ≥ 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- x_in  input  12  X position code, sampled on start.
- y_in  input  12  Y position code, sampled on start.
- start  input  1  single-cycle request to send one point.
- laser_rgb  input  3  laser colour enables {R,G,B}, sampled on start.
- dac_mosi  output  1  SPI data, MSB first.
- dac_CSN  output  1  SPI chip select, active low.
- dac_sclk  output  1  SPI clock, idle low.
- dac_latch  output  1  DAC LDAC, active low.
- done  output  1  one-cycle pulse when the point has been latched.
- laser_rgb_latched  output  3  colour synchronised to the DAC update.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: dac_mosi=0, dac_CSN=1, dac_sclk=0, dac_latch=1, done=0, laser_rgb_latched=0. FSM is in IDLE.
- Command word: {A/B, BUF=0, GA_n=1, SHDN_n=1, data[11:0]}.
  - X word: A/B=0 → {4'b0011, x}.
  - Y word: A/B=1 → {4'b1011, y}.
- FSM states: IDLE → SETUP_X → SHIFT_X → GAP_X → SETUP_Y → SHIFT_Y → GAP_Y → LATCH → DONE → IDLE.
- IDLE:
  - Outputs idle (CSN=1, sclk=0, latch=1).
  - When start=1, register x_in, y_in and laser_rgb, and load the X word.
- SETUP (1 cycle): CSN=0, sclk=0, mosi=word[15].
- SHIFT: 16 bits, each 2*CLK_DIV cycles.
  - sclk is high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - The DAC samples mosi on the sclk rising edge.
  - mosi advances to the next bit on the high→low transition.
  - After the 16th low phase, leave SHIFT. mosi is don't-care outside frames; drive 0.
- GAP: CSN=1, sclk=0 for CS_GAP cycles.
- LATCH:
  - dac_latch=0 for LATCH_W cycles.
  - laser_rgb_latched is loaded with the captured colour on LATCH entry, i.e. the same cycle latch first goes low.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency with defaults: 1+64+2 cycles per channel, plus latch 2, gives 136 busy cycles. done is high in the 137th cycle after the start edge. A new start is accepted in the cycle after done.
- start while not in IDLE is ignored; captured data is never altered mid-transaction.
- Holding start high in IDLE starts back-to-back transactions.
- Input changes after the start cycle have no effect on the current point.
- Reset mid-transaction: abort immediately to reset values. No latch pulse and no done are produced; laser_rgb_latched returns to 0.
- dac_sclk never toggles while CSN=1.
- Exactly 16 rising sclk edges occur per CSN-low window.

Decomposition:
- Shared package dac_pkg holds:
  - the state enum;
  - constants for config nibbles (CFG_X=4'b0011, CFG_Y=4'b1011);
  - the word width (16).
- One natural sub-module, spi_shift16: loads a 16-bit word and runs CSN/sclk/mosi with CLK_DIV timing, reporting frame done.
- The top FSM sequences the two frames, the gap, the latch and the done pulse.

Test Plan:
- Reset: assert reset mid-frame → next edge-independent check shows CSN=1, sclk=0, latch=1, done=0, rgb_latched=0; no latch pulse follows.
- Point 1: x=12'hF0F, y=12'h8F0, rgb=3'b101, start for 1 cycle.
  - Frame 1 sampled on sclk rising edges reads 16'h3F0F; frame 2 reads 16'hB8F0.
  - Then a 2-cycle latch low; rgb_latched=101 from latch entry; done pulses exactly 137 cycles after start.
- Point 2: x=0, y=0, start, rgb unchanged → words 16'h3000 and 16'hB000; done once; rgb_latched stays 101.
- Framing: on every transaction, count 16 sclk rising edges per CSN-low window, a CSN-high gap of ≥2 cycles between frames, and latch low only while CSN=1.
- Busy: pulse start again 20 cycles into a transaction with different data → ignored; words match the first capture; exactly one done.
- Inputs: change x_in/laser_rgb one cycle after start → transmitted data and rgb_latched use the values sampled at start.
